// File: rtl/fll_cfg_arbiter.sv
// Round-robin arbiter of NUM_REQ config requesters onto one FLL 4-phase port.
// Define FLL_CFG_ACK_SYNC_EN to pass fll_ack_i through a 2-flop synchronizer.
module fll_cfg_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ-1:0]      wrn_i,
    input  logic [2*NUM_REQ-1:0]    add_i,
    input  logic [32*NUM_REQ-1:0]   data_i,
    output logic [NUM_REQ-1:0]      ack_o,
    output logic [NUM_REQ-1:0]      err_o,
    output logic [31:0]             r_data_o,
    output logic                    fll_req_o,
    output logic                    fll_wrn_o,
    output logic [1:0]              fll_add_o,
    output logic [31:0]             fll_data_o,
    input  logic                    fll_ack_i,
    input  logic [31:0]             fll_r_data_i,
    output logic                    timeout_o
);

    localparam int PW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    localparam logic [15:0] TO_VAL  = 16'(TIMEOUT);
    localparam logic [31:0] ERR_DAT = 32'hDEAD_BEEF;

    logic [1:0]         state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      gnt_q, gnt_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               wrn_q, wrn_d;
    logic [1:0]         add_q, add_d;
    logic [31:0]        data_q, data_d;
    logic               fll_req_q, fll_req_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               timeout_q, timeout_d;

    logic               ack_smp;
    logic [PW:0]        pick;
    logic               pick_vld;
    logic [PW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [PW-1:0]      ptr_nxt;

    // First set request at or after p, scanning with wrap-around.
    function automatic logic [PW:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [PW-1:0]      p
    );
        logic          found;
        logic [PW-1:0] idx;
        int            s;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            s = int'(p) + i;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && r[k] && (k == s)) begin
                    found = 1'b1;
                    idx   = PW'(k);
                end
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        if (v == PW'(NUM_REQ - 1)) return '0;
        return v + PW'(1);
    endfunction

`ifdef FLL_CFG_ACK_SYNC_EN
    logic [1:0] ack_sync_q, ack_sync_d;

    always_comb begin
        ack_sync_d = {ack_sync_q[0], fll_ack_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_sync_q <= 2'b00;
        end else begin
            ack_sync_q <= ack_sync_d;
        end
    end

    assign ack_smp = ack_sync_q[1];
`else
    assign ack_smp = fll_ack_i;
`endif

    assign pick     = rr_pick(req_i, ptr_q);
    assign pick_vld = pick[PW];
    assign pick_idx = pick[PW-1:0];
    assign ptr_nxt  = wrap_inc(gnt_q);

    always_comb begin
        gnt_oh = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_q == PW'(k)) gnt_oh[k] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        wrn_d     = wrn_q;
        add_d     = add_q;
        data_d    = data_q;
        fll_req_d = fll_req_q;
        ack_d     = '0;
        err_d     = '0;
        rdata_d   = '0;
        timeout_d = timeout_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_d     = pick_idx;
                    state_d   = S_REQ;
                    cnt_d     = '0;
                    fll_req_d = 1'b1;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (pick_idx == PW'(k)) begin
                            wrn_d  = wrn_i[k];
                            add_d  = add_i[2*k +: 2];
                            data_d = data_i[32*k +: 32];
                        end
                    end
                end
            end
            S_REQ: begin
                if (ack_smp) begin
                    fll_req_d = 1'b0;
                    ack_d     = gnt_oh;
                    rdata_d   = wrn_q ? fll_r_data_i : 32'd0;
                    ptr_d     = ptr_nxt;
                    state_d   = S_REL;
                    cnt_d     = '0;
                end else if (cnt_q == TO_VAL) begin
                    // FLL never answered: complete the requester with an error.
                    fll_req_d = 1'b0;
                    ack_d     = gnt_oh;
                    err_d     = gnt_oh;
                    rdata_d   = ERR_DAT;
                    timeout_d = 1'b1;
                    ptr_d     = ptr_nxt;
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_REL: begin
                if (!ack_smp) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_VAL) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                fll_req_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            wrn_q     <= 1'b0;
            add_q     <= 2'd0;
            data_q    <= 32'd0;
            fll_req_q <= 1'b0;
            ack_q     <= '0;
            err_q     <= '0;
            rdata_q   <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            wrn_q     <= wrn_d;
            add_q     <= add_d;
            data_q    <= data_d;
            fll_req_q <= fll_req_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    assign ack_o      = ack_q;
    assign err_o      = err_q;
    assign r_data_o   = rdata_q;
    assign fll_req_o  = fll_req_q;
    assign fll_wrn_o  = wrn_q;
    assign fll_add_o  = add_q;
    assign fll_data_o = data_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_fll_cfg_arbiter.sv
// Directed bench for fll_cfg_arbiter: write, read, round-robin, timeout, reset abort.
// The FLL is modelled as a 4-phase slave that mirrors fll_req_o one cycle later.
module tb_fll_cfg_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  req_i = '0;
    logic [1:0]  wrn_i = '0;
    logic [3:0]  add_i = '0;
    logic [63:0] data_i = '0;
    logic [1:0]  ack_o;
    logic [1:0]  err_o;
    logic [31:0] r_data_o;
    logic        fll_req_o;
    logic        fll_wrn_o;
    logic [1:0]  fll_add_o;
    logic [31:0] fll_data_o;
    logic        fll_ack_i = 1'b0;
    logic [31:0] fll_r_data_i = 32'h5555_AAAA;
    logic        timeout_o;

    logic        fll_en = 1'b0;
    int          total = 0;
    int          bad = 0;

`ifdef FLL_CFG_ACK_SYNC_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    fll_cfg_arbiter #(.NUM_REQ(2), .TIMEOUT(255)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .wrn_i        (wrn_i),
        .add_i        (add_i),
        .data_i       (data_i),
        .ack_o        (ack_o),
        .err_o        (err_o),
        .r_data_o     (r_data_o),
        .fll_req_o    (fll_req_o),
        .fll_wrn_o    (fll_wrn_o),
        .fll_add_o    (fll_add_o),
        .fll_data_o   (fll_data_o),
        .fll_ack_i    (fll_ack_i),
        .fll_r_data_i (fll_r_data_i),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) fll_ack_i <= fll_en & fll_req_o;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Waits on negedges until ack_o rises; n is the number of negedges waited.
    task automatic wait_ack(input string tag, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (ack_o == 2'b00 && n < bound);
        chk(tag, 32'(ack_o != 2'b00), 32'd1);
    endtask

    initial begin
        int n;
        int seen;
        logic [1:0] exp_g;

        #1;
        chk("rst_fll_req", 32'(fll_req_o), 32'd0);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rdata", r_data_o, 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // single write from requester 0
        fll_en = 1'b1;
        req_i  = 2'b01;
        wrn_i  = 2'b00;
        add_i  = 4'b0010;
        data_i = {32'h0, 32'h1234_5678};
        @(negedge clk_i);
        chk("wr_fll_req", 32'(fll_req_o), 32'd1);
        chk("wr_fll_wrn", 32'(fll_wrn_o), 32'd0);
        chk("wr_fll_add", 32'(fll_add_o), 32'd2);
        chk("wr_fll_data", fll_data_o, 32'h1234_5678);
        wait_ack("wr_ack_seen", 20, n);
        chk("wr_lat", 32'(n + 1), 32'(LAT));
        chk("wr_ack", 32'(ack_o), 32'd1);
        chk("wr_err", 32'(err_o), 32'd0);
        chk("wr_rdata", r_data_o, 32'd0);
        chk("wr_req_drop", 32'(fll_req_o), 32'd0);
        req_i = 2'b00;
        @(negedge clk_i);
        chk("wr_ack_pulse", 32'(ack_o), 32'd0);
        chk("wr_rdata_idle", r_data_o, 32'd0);
        repeat (8) @(negedge clk_i);

        // read from requester 1
        req_i        = 2'b10;
        wrn_i        = 2'b10;
        add_i        = 4'b0100;
        fll_r_data_i = 32'hCAFE_0001;
        wait_ack("rd_ack_seen", 20, n);
        chk("rd_lat", 32'(n), 32'(LAT));
        chk("rd_ack", 32'(ack_o), 32'd2);
        chk("rd_err", 32'(err_o), 32'd0);
        chk("rd_rdata", r_data_o, 32'hCAFE_0001);
        req_i = 2'b00;
        @(negedge clk_i);
        chk("rd_rdata_idle", r_data_o, 32'd0);
        repeat (8) @(negedge clk_i);

        // contention, both held
        req_i = 2'b11;
        wrn_i = 2'b00;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            wait_ack("rr_ack_seen", 40, n);
            chk($sformatf("rr_grant%0d", t), 32'(ack_o), 32'(exp_g));
        end
        req_i = 2'b00;
        repeat (8) @(negedge clk_i);

        // FLL never acks
        fll_en = 1'b0;
        req_i  = 2'b01;
        wait_ack("to_ack_seen", 400, n);
        chk("to_lat", 32'(n), 32'd257);
        chk("to_ack", 32'(ack_o), 32'd1);
        chk("to_err", 32'(err_o), 32'd1);
        chk("to_rdata", r_data_o, 32'hDEAD_BEEF);
        chk("to_flag", 32'(timeout_o), 32'd1);
        chk("to_req_drop", 32'(fll_req_o), 32'd0);
        req_i = 2'b00;
        @(negedge clk_i);
        chk("to_ack_pulse", 32'(ack_o), 32'd0);
        chk("to_err_pulse", 32'(err_o), 32'd0);
        repeat (4) @(negedge clk_i);
        chk("to_sticky", 32'(timeout_o), 32'd1);

        // reset mid-transaction
        req_i = 2'b01;
        repeat (3) @(negedge clk_i);
        chk("ra_fll_req", 32'(fll_req_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("ra_async_req", 32'(fll_req_o), 32'd0);
        chk("ra_timeout_clr", 32'(timeout_o), 32'd0);
        req_i = 2'b00;
        @(negedge clk_i);
        rst_ni = 1'b1;
        fll_en = 1'b1;
        seen   = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (ack_o != 2'b00) seen++;
        end
        chk("ra_no_ack", 32'(seen), 32'd0);
        req_i = 2'b11;
        wait_ack("ra_ack_seen", 20, n);
        chk("ra_lat", 32'(n), 32'(LAT));
        chk("ra_grant0", 32'(ack_o), 32'd1);
        req_i = 2'b00;
        repeat (8) @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fll_cfg_arbiter.md
FLL_CFG_ARBITER -- requirements
Module: fll_cfg_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, SHALL set the number of requester ports (legal 2..4).
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum cycles to wait for an FLL ack edge (legal 1..65535).
REQ-003 clk_i  in  1  SHALL be the single clock; every flop SHALL be clocked on its rising edge.
REQ-004 rst_ni  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_i  in  NUM_REQ  SHALL carry one config request per requester.
REQ-006 wrn_i  in  NUM_REQ  SHALL carry the per-requester write-not (1=read, 0=write).
REQ-007 add_i  in  2*NUM_REQ  SHALL carry the per-requester register address; requester k uses bits [2k+1:2k].
REQ-008 data_i  in  32*NUM_REQ  SHALL carry the per-requester write data; requester k uses bits [32k+31:32k].
REQ-009 ack_o  out  NUM_REQ  SHALL carry the per-requester one-cycle completion pulse.
REQ-010 err_o  out  NUM_REQ  SHALL carry the per-requester timeout flag, valid with ack_o.
REQ-011 r_data_o  out  32  SHALL carry the shared read data, valid while any ack_o bit is 1.
REQ-012 fll_req_o, fll_wrn_o, fll_add_o[1:0], fll_data_o[31:0]  out  SHALL form the FLL config request.
REQ-013 fll_ack_i  in  1, fll_r_data_i  in  32  SHALL carry the FLL config response.
REQ-014 timeout_o  out  1  SHALL be a sticky flag set by any timeout.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ and RELEASE.
REQ-016 In IDLE with any req_i bit high, the block SHALL grant the first set bit at or after pointer ptr, wrapping modulo NUM_REQ, and SHALL latch that requester's wrn, add and data.
REQ-017 In that same cycle the FSM SHALL move to REQ; fll_req_o SHALL be 1 from the next cycle until the cycle after the sampled ack is seen high.
REQ-018 fll_wrn_o, fll_add_o and fll_data_o SHALL be driven from the latched values and SHALL stay stable for the whole REQ state.
REQ-019 In REQ with the sampled ack high, the block SHALL, in the next cycle, drop fll_req_o, pulse ack_o[grant] for one cycle, and drive r_data_o with fll_r_data_i as captured on the ack (0 for writes); the FSM SHALL then enter RELEASE.
REQ-020 In RELEASE with the sampled ack low, the FSM SHALL return to IDLE, completing the 4-phase handshake.
REQ-021 ptr SHALL be set to grant+1 (mod NUM_REQ) on every completion, success or timeout, giving round-robin fairness.
REQ-022 A 16-bit counter SHALL clear on entry to REQ or RELEASE and SHALL increment every cycle in those states.
REQ-023 If the counter reaches TIMEOUT in REQ, the block SHALL drop fll_req_o, pulse ack_o[grant] and err_o[grant], drive r_data_o=32'hDEAD_BEEF, set timeout_o, and go to IDLE.
REQ-024 If the counter reaches TIMEOUT in RELEASE, the block SHALL set timeout_o and go to IDLE, with no ack_o pulse.
REQ-025 When no ack_o bit is high, ack_o, err_o and r_data_o SHALL all be 0.
REQ-026 A requester holding req_i high after its ack_o SHALL be treated as a new request, arbitrated normally in IDLE.
REQ-027 Requests arriving while the FSM is not in IDLE SHALL wait, and no requester SHALL be dropped.
REQ-028 Minimum transaction latency (req_i to ack_o) SHALL be 3 cycles with an immediate FLL ack and no synchronizer.

Reset
REQ-029 With rst_ni low, the block SHALL be in IDLE with ptr=0, counter=0, and all outputs 0 (fll_req_o=0, ack_o=0, err_o=0, r_data_o=0, timeout_o=0).
REQ-030 An rst_ni assertion mid-transaction SHALL abort it immediately, with no ack_o pulse after reset release.

Configuration
REQ-031 With FLL_CFG_ACK_SYNC_EN defined, fll_ack_i SHALL pass through a 2-flop synchronizer (reset to 0) before FSM use, adding 2 cycles to every ack edge.
REQ-032 Without FLL_CFG_ACK_SYNC_EN, fll_ack_i SHALL be sampled directly by the FSM.

Verification
REQ-033 Single write: req_i=01, wrn=0, add=2, data=32'h1234_5678, FLL acks 1 cycle after fll_req_o -> fll_add_o=2, fll_data_o=32'h1234_5678, ack_o=01 for one cycle, err_o=0.
REQ-034 Read: FLL returns fll_r_data_i=32'hCAFE_0001 with ack -> r_data_o=32'hCAFE_0001 exactly in the ack_o cycle.
REQ-035 Contention: req_i=11 held for 4 transactions -> grants in order 0,1,0,1.
REQ-036 fll_ack_i stuck low, TIMEOUT=255 -> ack_o and err_o pulse 256 cycles after fll_req_o rises, r_data_o=32'hDEAD_BEEF, timeout_o=1 sticky.
REQ-037 rst_ni pulsed low while in REQ -> fll_req_o=0 asynchronously, no later ack_o, next grant uses requester 0.
REQ-038 With FLL_CFG_ACK_SYNC_EN defined, the REQ-033 scenario -> ack_o arrives 2 cycles later than without the macro.
